regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port between three writeback sources: 0 = ALU, 1 = LSU, 2 = MDU.
- Keeps a destination-register scoreboard and flags RAW/WAW hazards to the issue stage.
- Sits between the execute/memory units and the register file write port (reg_write, rd_addr, write_data).
- All write-port outputs are registered.

---
 rtl/regfile_wb_arbiter_if.sv | 38 +++
 rtl/regfile_wb_arbiter.sv | 95 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback requester bus, register-file write port and issue-stage scoreboard
// signals of regfile_wb_arbiter. The arbiter uses the slave modport.
interface regfile_wb_arbiter_if #(
   parameter int NREQ = 3,
   parameter int DW   = 32,
   parameter int AW   = 5
);
   logic [NREQ-1:0]    req_valid_i;
   logic [NREQ*AW-1:0] req_rd_i;
   logic [NREQ*DW-1:0] req_data_i;
   logic [NREQ-1:0]    req_ready_o;

   logic               reg_write_o;
   logic [AW-1:0]      rd_addr_o;
   logic [DW-1:0]      write_data_o;

   logic               issue_valid_i;
   logic [AW-1:0]      issue_rd_i;
   logic               issue_stall_o;
   logic [AW-1:0]      rs1_addr_i;
   logic [AW-1:0]      rs2_addr_i;
   logic               rs1_busy_o;
   logic               rs2_busy_o;

   modport master (
      output req_valid_i, req_rd_i, req_data_i,
      output issue_valid_i, issue_rd_i, rs1_addr_i, rs2_addr_i,
      input  req_ready_o, reg_write_o, rd_addr_o, write_data_o,
      input  issue_stall_o, rs1_busy_o, rs2_busy_o
   );

   modport slave (
      input  req_valid_i, req_rd_i, req_data_i,
      input  issue_valid_i, issue_rd_i, rs1_addr_i, rs2_addr_i,
      output req_ready_o, reg_write_o, rd_addr_o, write_data_o,
      output issue_stall_o, rs1_busy_o, rs2_busy_o
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU(0)/LSU(1)/MDU(2) and keeps a
// destination scoreboard for RAW/WAW hazards. WB_ARB_RR_EN selects round-robin arbitration.
module regfile_wb_arbiter #(
   parameter int NREQ = 3,
   parameter int DW   = 32,
   parameter int AW   = 5
) (
   input logic                 clk,
   input logic                 rst_n,
   regfile_wb_arbiter_if.slave bus
);

   logic          grant_any;
   logic [1:0]    grant_idx;
   logic [AW-1:0] sel_rd;
   logic [DW-1:0] sel_data;

`ifdef WB_ARB_RR_EN
   logic [1:0] ptr;
   logic [1:0] cand;

   function automatic logic [1:0] rr_idx(input logic [1:0] p, input logic [1:0] k);
      logic [2:0] s;
      s = {1'b0, p} + {1'b0, k};
      return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
   endfunction

   // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = 2'd0;
      cand      = 2'd0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = rr_idx(ptr, 2'(k));
         if (!grant_any && bus.req_valid_i[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
   end

   // Pointer resets to the MDU slot so the first search starts at the ALU.
   always_ff @(posedge clk) begin
      if (!rst_n)         ptr <= 2'd2;
      else if (grant_any) ptr <= grant_idx;
   end
`else
   always_comb begin
      grant_any = |bus.req_valid_i;
      grant_idx = bus.req_valid_i[2] ? 2'd2 : (bus.req_valid_i[1] ? 2'd1 : 2'd0);
   end
`endif

   assign bus.req_ready_o = grant_any ? (NREQ'(1) << grant_idx) : '0;
   assign sel_rd          = bus.req_rd_i[grant_idx*AW +: AW];
   assign sel_data        = bus.req_data_i[grant_idx*DW +: DW];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.reg_write_o  <= 1'b0;
         bus.rd_addr_o    <= '0;
         bus.write_data_o <= '0;
      end else begin
         bus.reg_write_o <= grant_any && (sel_rd != '0);
         if (grant_any) begin
            bus.rd_addr_o    <= sel_rd;
            bus.write_data_o <= sel_data;
         end
      end
   end

   logic [2**AW-1:0] busy;
   logic [2**AW-1:0] busy_nxt;
   logic             issue_take;

   assign bus.issue_stall_o = bus.issue_valid_i && (bus.issue_rd_i != '0) && busy[bus.issue_rd_i];
   assign issue_take        = bus.issue_valid_i && !bus.issue_stall_o && (bus.issue_rd_i != '0);
   assign bus.rs1_busy_o    = (bus.rs1_addr_i != '0) && busy[bus.rs1_addr_i];
   assign bus.rs2_busy_o    = (bus.rs2_addr_i != '0) && busy[bus.rs2_addr_i];

   // Clear first, then set, so a same-cycle issue of the written register stays busy.
   always_comb begin
      busy_nxt = busy;
      if (bus.reg_write_o) busy_nxt[bus.rd_addr_o] = 1'b0;
      if (issue_take)      busy_nxt[bus.issue_rd_i] = 1'b1;
   end

   // NOTE: unlike a data RAM, the scoreboard is flop state that must be reset; stale bits would stall issue forever.
   always_ff @(posedge clk) begin
      if (!rst_n) busy <= '0;
      else        busy <= busy_nxt;
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, hand-written contention/reset
// sequences, then random traffic against a behavioural model of arbitration and scoreboard.
module tb_regfile_wb_arbiter;
   localparam int NREQ = 3;
   localparam int DW   = 32;
   localparam int AW   = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   regfile_wb_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();
   regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic        rst;
      logic [2:0]  valid;
      logic [14:0] rd;
      logic [95:0] data;
      logic        iv;
      logic [4:0]  ird;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  e_ready;
      logic        e_stall;
      logic        e_rs1;
      logic        e_rs2;
      logic        e_wr;
      logic [4:0]  e_addr;
      logic [31:0] e_data;
   } vec_t;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rst, input logic [2:0] valid, input logic [14:0] rd,
                               input logic [95:0] data, input logic iv, input logic [4:0] ird,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [2:0] e_ready, input logic e_stall, input logic e_rs1,
                               input logic e_rs2, input logic e_wr, input logic [4:0] e_addr,
                               input logic [31:0] e_data);
      vec_t v;
      v.rst = rst; v.valid = valid; v.rd = rd; v.data = data;
      v.iv = iv; v.ird = ird; v.rs1 = rs1; v.rs2 = rs2;
      v.e_ready = e_ready; v.e_stall = e_stall; v.e_rs1 = e_rs1; v.e_rs2 = e_rs2;
      v.e_wr = e_wr; v.e_addr = e_addr; v.e_data = e_data;
      return v;
   endfunction

   // Single-requester vector; idle slices carry junk so a wrong slice select shows up.
   function automatic vec_t mk1(input logic [2:0] valid, input logic [4:0] rd, input logic [31:0] data,
                                input logic iv, input logic [4:0] ird, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] e_ready, input logic e_stall,
                                input logic e_rs1, input logic e_rs2, input logic e_wr,
                                input logic [4:0] e_addr, input logic [31:0] e_data);
      logic [14:0] rdp;
      logic [95:0] dp;
      for (int j = 0; j < 3; j++) begin
         rdp[j*5 +: 5]  = valid[j] ? rd : 5'(20 + j);
         dp[j*32 +: 32] = valid[j] ? data : (32'hDEAD_0000 | 32'(j));
      end
      return mk(1'b0, valid, rdp, dp, iv, ird, rs1, rs2, e_ready, e_stall, e_rs1, e_rs2,
                e_wr, e_addr, e_data);
   endfunction

   task automatic apply(input vec_t v, input string tag);
      rst_n             = !v.rst;
      bus.req_valid_i   = v.valid;
      bus.req_rd_i      = v.rd;
      bus.req_data_i    = v.data;
      bus.issue_valid_i = v.iv;
      bus.issue_rd_i    = v.ird;
      bus.rs1_addr_i    = v.rs1;
      bus.rs2_addr_i    = v.rs2;
      @(negedge clk);
      if (!v.rst) begin
         check($sformatf("%s ready", tag), 32'(bus.req_ready_o), 32'(v.e_ready));
         check($sformatf("%s stall", tag), 32'(bus.issue_stall_o), 32'(v.e_stall));
         check($sformatf("%s rs1_busy", tag), 32'(bus.rs1_busy_o), 32'(v.e_rs1));
         check($sformatf("%s rs2_busy", tag), 32'(bus.rs2_busy_o), 32'(v.e_rs2));
      end
      @(posedge clk);
      #1;
      check($sformatf("%s reg_write", tag), 32'(bus.reg_write_o), 32'(v.e_wr));
      check($sformatf("%s rd_addr", tag), 32'(bus.rd_addr_o), 32'(v.e_addr));
      check($sformatf("%s write_data", tag), bus.write_data_o, v.e_data);
   endtask

   vec_t tbl[13];
   vec_t rst_v;

   localparam logic [14:0] CON_RD   = {5'd3, 5'd2, 5'd1};
   localparam logic [95:0] CON_DATA = {32'h0000_0303, 32'h0000_0202, 32'h0000_0101};
   localparam logic [14:0] RST_RD   = {5'd14, 5'd13, 5'd12};
   localparam logic [95:0] RST_DATA = {32'h0000_00E2, 32'h0000_00E1, 32'h0000_00E0};

   // Reference-model state for the random phase
   bit          pend[3];
   logic [4:0]  prd[3];
   logic [31:0] pdat[3];
   bit          busy_m[32];
   bit          wr_m;
   logic [4:0]  addr_m;
   logic [31:0] data_m;
   int          last_m;

   initial begin
      rst_v = mk(1'b1, 3'b000, '0, '0, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0,
                 1'b0, 5'd0, 32'h0);

      //            valid   rd     data           iv    ird    rs1    rs2   ready   stl  b1    b2    wr    addr   wdata
      tbl[0]  = mk1(3'b000, 5'd0, 32'h0,         1'b0, 5'd0,  5'd0,  5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      tbl[1]  = mk1(3'b001, 5'd5, 32'h0000_00AA, 1'b0, 5'd0,  5'd0,  5'd0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'hAA);
      tbl[2]  = mk1(3'b000, 5'd0, 32'h0,         1'b1, 5'd7,  5'd0,  5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 32'hAA);
      tbl[3]  = mk1(3'b000, 5'd0, 32'h0,         1'b1, 5'd7,  5'd7,  5'd0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'hAA);
      tbl[4]  = mk1(3'b010, 5'd7, 32'h0000_0077, 1'b0, 5'd0,  5'd7,  5'd0, 3'b010, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h77);
      tbl[5]  = mk1(3'b000, 5'd0, 32'h0,         1'b1, 5'd7,  5'd7,  5'd0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 32'h77);
      tbl[6]  = mk1(3'b000, 5'd0, 32'h0,         1'b1, 5'd7,  5'd7,  5'd7, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 32'h77);
      tbl[7]  = mk1(3'b000, 5'd0, 32'h0,         1'b0, 5'd0,  5'd0,  5'd7, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 32'h77);
      tbl[8]  = mk1(3'b100, 5'd9, 32'h0000_0099, 1'b0, 5'd0,  5'd9,  5'd0, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h99);
      tbl[9]  = mk1(3'b000, 5'd0, 32'h0,         1'b1, 5'd9,  5'd9,  5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 32'h99);
      tbl[10] = mk1(3'b000, 5'd0, 32'h0,         1'b1, 5'd9,  5'd9,  5'd0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 32'h99);
      tbl[11] = mk1(3'b001, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0,  5'd0,  5'd0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'hFFFF_FFFF);
      tbl[12] = mk1(3'b000, 5'd0, 32'h0,         1'b1, 5'd0,  5'd0,  5'd7, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF);

      apply(rst_v, "reset0");
      apply(rst_v, "reset1");
      for (int i = 0; i < 13; i++) apply(tbl[i], $sformatf("tbl%0d", i));

      // Contention from a fresh reset
      apply(rst_v, "reset2");
`ifdef WB_ARB_RR_EN
      apply(mk(1'b0, 3'b111, CON_RD, CON_DATA, 1'b0, 5'd0, 5'd0, 5'd0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 32'h101), "rr0");
      apply(mk(1'b0, 3'b111, CON_RD, CON_DATA, 1'b0, 5'd0, 5'd0, 5'd0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 32'h202), "rr1");
      apply(mk(1'b0, 3'b111, CON_RD, CON_DATA, 1'b0, 5'd0, 5'd0, 5'd0, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h303), "rr2");
      apply(mk(1'b0, 3'b111, CON_RD, CON_DATA, 1'b0, 5'd0, 5'd0, 5'd0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 32'h101), "rr3");
`else
      apply(mk(1'b0, 3'b111, CON_RD, CON_DATA, 1'b0, 5'd0, 5'd0, 5'd0, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h303), "fp0");
      apply(mk(1'b0, 3'b011, CON_RD, CON_DATA, 1'b0, 5'd0, 5'd0, 5'd0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 32'h202), "fp1");
      apply(mk(1'b0, 3'b001, CON_RD, CON_DATA, 1'b0, 5'd0, 5'd0, 5'd0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 32'h101), "fp2");
      apply(mk(1'b0, 3'b000, CON_RD, CON_DATA, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 32'h101), "fp3");
`endif
      apply(mk(1'b0, 3'b000, CON_RD, CON_DATA, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 32'h101), "idle");

      // Reset in the middle of contention with a pending destination
      apply(mk(1'b0, 3'b000, RST_RD, RST_DATA, 1'b1, 5'd12, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 32'h101), "mr0");
      apply(mk(1'b1, 3'b111, RST_RD, RST_DATA, 1'b1, 5'd13, 5'd12, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0), "mr1");
      apply(mk(1'b0, 3'b000, RST_RD, RST_DATA, 1'b1, 5'd12, 5'd12, 5'd13, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0), "mr2");
`ifdef WB_ARB_RR_EN
      apply(mk(1'b0, 3'b111, RST_RD, RST_DATA, 1'b0, 5'd0, 5'd12, 5'd0, 3'b001, 1'b0, 1'b1, 1'b0, 1'b1, 5'd12, 32'hE0), "mr3");
`else
      apply(mk(1'b0, 3'b111, RST_RD, RST_DATA, 1'b0, 5'd0, 5'd12, 5'd0, 3'b100, 1'b0, 1'b1, 1'b0, 1'b1, 5'd14, 32'hE2), "mr3");
`endif

      // Random traffic against the behavioural model
      for (int i = 0; i < 3; i++) pend[i] = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         vec_t        v;
         bit          do_rst;
         int          g;
         logic [14:0] rdp;
         logic [95:0] dp;
         logic [2:0]  vld;
         logic        iv;
         logic [4:0]  ird, rs1, rs2;
         logic        e_stall;

         do_rst = (c == 0) || ($urandom_range(0, 99) == 0);
         for (int i = 0; i < 3; i++) begin
            if (!pend[i] && $urandom_range(0, 2) != 0) begin
               pend[i] = 1'b1;
               prd[i]  = 5'($urandom_range(0, 15));
               pdat[i] = $urandom;
            end
            vld[i]          = pend[i];
            rdp[i*5 +: 5]   = pend[i] ? prd[i] : 5'($urandom);
            dp[i*32 +: 32]  = pend[i] ? pdat[i] : $urandom;
         end
         iv  = 1'($urandom_range(0, 1));
         ird = 5'($urandom_range(0, 15));
         rs1 = 5'($urandom_range(0, 15));
         rs2 = 5'($urandom_range(0, 15));

         g = -1;
`ifdef WB_ARB_RR_EN
         for (int k = 1; k <= 3; k++)
            if (g < 0 && pend[(last_m + k) % 3]) g = (last_m + k) % 3;
`else
         for (int i = 2; i >= 0; i--)
            if (g < 0 && pend[i]) g = i;
`endif
         e_stall = iv && (ird != 0) && busy_m[ird];
         v = mk(do_rst, vld, rdp, dp, iv, ird, rs1, rs2,
                (g >= 0) ? 3'(1 << g) : 3'b000, e_stall,
                (rs1 != 0) && busy_m[rs1], (rs2 != 0) && busy_m[rs2],
                1'b0, 5'd0, 32'h0);

         if (do_rst) begin
            for (int r = 0; r < 32; r++) busy_m[r] = 1'b0;
            for (int i = 0; i < 3; i++) pend[i] = 1'b0;
            wr_m = 1'b0; addr_m = 5'd0; data_m = 32'h0; last_m = 2;
         end else begin
            if (wr_m) busy_m[addr_m] = 1'b0;
            if (iv && !e_stall && ird != 0) busy_m[ird] = 1'b1;
            if (g >= 0) begin
               wr_m    = (prd[g] != 0);
               addr_m  = prd[g];
               data_m  = pdat[g];
               pend[g] = 1'b0;
               last_m  = g;
            end else begin
               wr_m = 1'b0;
            end
         end
         v.e_wr = wr_m; v.e_addr = addr_m; v.e_data = data_m;
         apply(v, $sformatf("rand%0d", c));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
